// File: rtl/tlb_refill_ctrl.sv
// Translation sequencer: TLB lookup, single-level page-table walk on miss, random-write refill.
// Define TLBR_TIMEOUT_EN to abort a walk after TIMEOUT cycles without mem_ack.
module tlb_refill_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic [19:0] vpn,
  input  logic [31:0] ptbr,
  input  logic        tlb_hit,
  input  logic [23:0] tlb_pte,
  output logic [19:0] tlb_vpn,
  output logic        tlbwr,
  output logic [23:0] pte_wr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [23:0] pte_out
);

  typedef enum logic [2:0] {IDLE, LOOKUP, WALK, FILL, DONE} state_t;

  state_t      state_reg, state_next;
  logic [19:0] tlb_vpn_reg, tlb_vpn_next;
  logic [23:0] pte_wr_reg, pte_wr_next;
  logic [23:0] pte_out_reg, pte_out_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic        fault_reg, fault_next;
  logic        walk_expired;

  // Only the PTE field of the page-table word is meaningful.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^mem_rdata[31:24];

`ifdef TLBR_TIMEOUT_EN
  parameter int unsigned TIMEOUT = 255;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  // cnt_reg counts completed ack-less WALK cycles; the last allowed one ends the walk.
  assign walk_expired = (cnt_reg == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == LOOKUP)
      cnt_next = '0;
    else if (state_reg == WALK && !mem_ack)
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end
`else
  assign walk_expired = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    tlb_vpn_next  = tlb_vpn_reg;
    pte_wr_next   = pte_wr_reg;
    pte_out_next  = pte_out_reg;
    mem_addr_next = mem_addr_reg;
    fault_next    = fault_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          tlb_vpn_next = vpn;
          state_next   = LOOKUP;
        end
      end
      LOOKUP: begin
        if (tlb_hit) begin
          pte_out_next = tlb_pte;
          fault_next   = 1'b0;
          state_next   = DONE;
        end else begin
          mem_addr_next = ptbr + {10'b0, tlb_vpn_reg, 2'b00};
          state_next    = WALK;
        end
      end
      WALK: begin
        // An ack arriving in the expiry cycle still completes the walk.
        if (mem_ack) begin
          pte_out_next = mem_rdata[23:0];
          if (mem_rdata[0]) begin
            pte_wr_next = mem_rdata[23:0];
            state_next  = FILL;
          end else begin
            fault_next = 1'b1;
            state_next = DONE;
          end
        end else if (walk_expired) begin
          pte_out_next = '0;
          fault_next   = 1'b1;
          state_next   = DONE;
        end
      end
      FILL: begin
        fault_next = 1'b0;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg    <= IDLE;
      tlb_vpn_reg  <= '0;
      pte_wr_reg   <= '0;
      pte_out_reg  <= '0;
      mem_addr_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tlb_vpn_reg  <= tlb_vpn_next;
      pte_wr_reg   <= pte_wr_next;
      pte_out_reg  <= pte_out_next;
      mem_addr_reg <= mem_addr_next;
      fault_reg    <= fault_next;
    end
  end

  // Strobes are pure state decodes so that reset removes them without waiting for a clock.
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign tlbwr    = (state_reg == FILL);
  assign mem_req  = (state_reg == WALK);
  assign tlb_vpn  = tlb_vpn_reg;
  assign pte_wr   = pte_wr_reg;
  assign pte_out  = pte_out_reg;
  assign mem_addr = mem_addr_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Bench for tlb_refill_ctrl: TLB/memory environment, directed table, corner sequences, random vs. model.
module tb_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        clrn, req, tlb_hit, tlbwr, mem_req, mem_ack, busy, done, fault;
  logic [19:0] vpn, tlb_vpn;
  logic [31:0] ptbr, mem_addr, mem_rdata;
  logic [23:0] tlb_pte, pte_wr, pte_out;

  always #5 clk = ~clk;

`ifdef TLBR_TIMEOUT_EN
  localparam int T = 4;
  tlb_refill_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .clrn(clrn), .req(req), .vpn(vpn), .ptbr(ptbr),
    .tlb_hit(tlb_hit), .tlb_pte(tlb_pte), .tlb_vpn(tlb_vpn), .tlbwr(tlbwr), .pte_wr(pte_wr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fault(fault), .pte_out(pte_out));
`else
  tlb_refill_ctrl dut (
    .clk(clk), .clrn(clrn), .req(req), .vpn(vpn), .ptbr(ptbr),
    .tlb_hit(tlb_hit), .tlb_pte(tlb_pte), .tlb_vpn(tlb_vpn), .tlbwr(tlbwr), .pte_wr(pte_wr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .fault(fault), .pte_out(pte_out));
`endif

  // Environment TLB: 8 entries, fully associative, random replacement on tlbwr.
  logic        e_v [8];
  logic [19:0] e_vpn [8];
  logic [23:0] e_pte [8];
  logic        env_clr, load_en;
  int          load_slot, wr_slot;
  logic [19:0] load_vpn;
  logic [23:0] load_pte;

  always_comb begin
    tlb_hit = 1'b0;
    tlb_pte = '0;
    for (int i = 0; i < 8; i++)
      if (e_v[i] && e_vpn[i] == tlb_vpn) begin
        tlb_hit = 1'b1;
        tlb_pte = e_pte[i];
      end
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) e_v[i] = 1'b0;
    end else if (load_en) begin
      e_v[load_slot] = 1'b1; e_vpn[load_slot] = load_vpn; e_pte[load_slot] = load_pte;
    end else if (tlbwr) begin
      wr_slot = $urandom_range(0, 7);
      e_v[wr_slot] = 1'b1; e_vpn[wr_slot] = tlb_vpn; e_pte[wr_slot] = pte_wr;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic        fault;
    logic [23:0] pte;
    int          walk;
    logic [31:0] addr;
    logic        addr_stable;
    int          wr;
    logic [23:0] pte_wr;
    logic [19:0] wr_vpn;
  } obs_t;

  // Issue one request at edge N and watch until done; cycle 1 is the cycle after edge N.
  task automatic run_req(input logic [19:0] v, input logic [31:0] base, input int dly,
                         input logic [31:0] word, input logic toggle, output obs_t o);
    o = '{lat: -1, fault: 1'b0, pte: '0, walk: 0, addr: '0, addr_stable: 1'b1,
          wr: 0, pte_wr: '0, wr_vpn: '0};
    @(negedge clk);
    vpn = v; ptbr = base; req = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 200 && o.lat < 0; c++) begin
      if (mem_req) begin
        if (o.walk == 0) o.addr = mem_addr;
        else if (mem_addr !== o.addr) o.addr_stable = 1'b0;
        o.walk++;
      end
      if (tlbwr) begin o.wr++; o.pte_wr = pte_wr; o.wr_vpn = tlb_vpn; end
      if (done) begin o.lat = c; o.fault = fault; o.pte = pte_out; end
      req = (toggle && !done) ? c[0] : 1'b0;
      if (mem_req) begin
        mem_ack   = (o.walk == dly + 1);
        mem_rdata = mem_ack ? word : $urandom;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; req = 1'b0;
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  // Reference outcome derived from the latency and result rules.
  function automatic obs_t model(input logic hit, input logic [23:0] hit_pte, input logic [19:0] v,
                                 input logic [31:0] base, input int dly, input logic [31:0] word);
    obs_t e;
    int ack_walk;
    e = '{lat: 2, fault: 1'b0, pte: hit_pte, walk: 0, addr: '0, addr_stable: 1'b1,
          wr: 0, pte_wr: '0, wr_vpn: v};
    if (hit) return e;
    e.addr = base + 32'(v) * 32'd4;
    ack_walk = dly + 1;
`ifdef TLBR_TIMEOUT_EN
    if (ack_walk > T) begin
      e.walk = T; e.lat = 2 + T; e.fault = 1'b1; e.pte = '0;
      return e;
    end
`endif
    e.walk = ack_walk;
    e.pte  = word[23:0];
    if (word[0]) begin
      e.lat = 3 + ack_walk; e.wr = 1; e.pte_wr = word[23:0];
    end else begin
      e.lat = 2 + ack_walk; e.fault = 1'b1;
    end
    return e;
  endfunction

  task automatic compare(input string tag, input obs_t o, input obs_t e);
    chk({tag, "_latency"}, 32'(o.lat), 32'(e.lat));
    chk({tag, "_fault"}, 32'(o.fault), 32'(e.fault));
    chk({tag, "_pte_out"}, 32'(o.pte), 32'(e.pte));
    chk({tag, "_walk_cycles"}, 32'(o.walk), 32'(e.walk));
    chk({tag, "_tlbwr_count"}, 32'(o.wr), 32'(e.wr));
    if (e.walk > 0) begin
      chk({tag, "_mem_addr"}, o.addr, e.addr);
      chk({tag, "_addr_stable"}, 32'(o.addr_stable), 32'd1);
    end
    if (e.wr > 0) begin
      chk({tag, "_pte_wr"}, 32'(o.pte_wr), 32'(e.pte_wr));
      chk({tag, "_wr_vpn"}, 32'(o.wr_vpn), 32'(e.wr_vpn));
    end
  endtask

  function automatic void env_lookup(input logic [19:0] v, output logic hit, output logic [23:0] pte);
    hit = 1'b0; pte = '0;
    for (int i = 0; i < 8; i++)
      if (e_v[i] && e_vpn[i] == v) begin hit = 1'b1; pte = e_pte[i]; end
  endfunction

  typedef struct {
    logic [19:0] v;
    logic [31:0] base;
    int          dly;
    logic [31:0] word;
    int          lat;
    logic        fault;
    logic [23:0] pte;
    int          walk;
    logic [31:0] addr;
    int          wr;
  } vec_t;

  vec_t        tab[$];
  obs_t        o, e;
  logic        hit;
  logic [23:0] hpte;
  logic [31:0] pt [12];
  int          cnt_done, cnt_wr, cnt_busy;

  initial begin
    tab.push_back('{20'h12345, 32'h0010_0000, 0, 32'h0,         2, 1'b0, 24'hABCD01, 0, 32'h0,         0});
    tab.push_back('{20'h00003, 32'h0010_0000, 3, 32'h0055_5561, 7, 1'b0, 24'h555561, 4, 32'h0010_000C, 1});
    tab.push_back('{20'h00003, 32'h0010_0000, 0, 32'h0,         2, 1'b0, 24'h555561, 0, 32'h0,         0});
    tab.push_back('{20'h00077, 32'h0010_0000, 0, 32'h0,         3, 1'b1, 24'h000000, 1, 32'h0010_01DC, 0});
    tab.push_back('{20'h00077, 32'h0010_0000, 1, 32'h0000_0A50, 4, 1'b1, 24'h000A50, 2, 32'h0010_01DC, 0});
    tab.push_back('{20'h00008, 32'hFFFF_FFF0, 1, 32'h0000_0AB1, 5, 1'b0, 24'h000AB1, 2, 32'h0000_0010, 1});
`ifdef TLBR_TIMEOUT_EN
    tab.push_back('{20'h00040, 32'h0020_0000, 50, 32'h0000_0001, 6, 1'b1, 24'h000000, 4, 32'h0020_0100, 0});
    tab.push_back('{20'h00041, 32'h0020_0000, 3, 32'h0012_3457, 7, 1'b0, 24'h123457, 4, 32'h0020_0104, 1});
`endif

    clrn = 1'b0; req = 1'b0; vpn = '0; ptbr = '0; mem_ack = 1'b0; mem_rdata = '0;
    env_clr = 1'b1; load_en = 1'b0; load_slot = 5; load_vpn = 20'h12345; load_pte = 24'hABCD01;
    @(negedge clk);
    env_clr = 1'b0; load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    chk("rst_tlb_vpn", 32'(tlb_vpn), 32'd0);
    chk("rst_pte_wr", 32'(pte_wr), 32'd0);
    chk("rst_pte_out", 32'(pte_out), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_strobes", {27'd0, tlbwr, mem_req, busy, done, fault}, 32'd0);
    clrn = 1'b1;

    foreach (tab[i]) begin
      run_req(tab[i].v, tab[i].base, tab[i].dly, tab[i].word, 1'b0, o);
      e = '{lat: tab[i].lat, fault: tab[i].fault, pte: tab[i].pte, walk: tab[i].walk,
            addr: tab[i].addr, addr_stable: 1'b1, wr: tab[i].wr, pte_wr: tab[i].pte,
            wr_vpn: tab[i].v};
      compare($sformatf("vec%0d", i), o, e);
      $display("vec %0d vpn=%05h lat=%0d fault=%0b pte=%06h walk=%0d", i, tab[i].v, o.lat, o.fault, o.pte, o.walk);
    end

    // Request toggled throughout a walk must produce exactly one completion.
    run_req(20'h00010, 32'h0000_1000, 2, 32'h00AB_C001, 1'b1, o);
    e = model(1'b0, 24'h0, 20'h00010, 32'h0000_1000, 2, 32'h00AB_C001);
    compare("busy_toggle", o, e);
    cnt_done = 0; cnt_busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cnt_done += int'(done); cnt_busy += int'(busy);
    end
    chk("busy_toggle_extra_done", 32'(cnt_done), 32'd0);
    chk("busy_toggle_extra_busy", 32'(cnt_busy), 32'd0);
    $display("seq busy_toggle lat=%0d pte=%06h", o.lat, o.pte);

    // Reset asserted mid-walk.
    @(negedge clk);
    vpn = 20'h00020; ptbr = 32'h0000_3000; req = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    req = 1'b0;
    cnt_busy = 0;
    for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
    chk("rstwalk_in_walk", 32'(mem_req), 32'd1);
    @(negedge clk);
    #1 clrn = 1'b0;
    #1;
    chk("rstwalk_mem_req", 32'(mem_req), 32'd0);
    chk("rstwalk_busy", 32'(busy), 32'd0);
    chk("rstwalk_mem_addr", mem_addr, 32'd0);
    chk("rstwalk_tlb_vpn", 32'(tlb_vpn), 32'd0);
    @(negedge clk);
    clrn = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_7771;
    cnt_wr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cnt_wr += int'(tlbwr); cnt_busy += int'(busy);
    end
    mem_ack = 1'b0;
    chk("rstwalk_no_tlbwr", 32'(cnt_wr), 32'd0);
    chk("rstwalk_stays_idle", 32'(cnt_busy), 32'd0);
    $display("seq reset_mid_walk tlbwr=%0d busy=%0d", cnt_wr, cnt_busy);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 12; i++) pt[i] = $urandom & 32'h00FF_FFFF;
    for (int n = 0; n < 40; n++) begin
      logic [19:0] rv;
      logic [31:0] rb;
      int          rd, idx;
      idx = $urandom_range(0, 11);
      rv  = 20'h00100 + 20'(idx);
      rb  = $urandom;
      rd  = $urandom_range(0, 6);
      env_lookup(rv, hit, hpte);
      e = model(hit, hpte, rv, rb, rd, pt[idx]);
      run_req(rv, rb, rd, pt[idx], 1'b0, o);
      compare($sformatf("rnd%0d", n), o, e);
      $display("rnd %0d vpn=%05h hit=%0b dly=%0d lat=%0d fault=%0b pte=%06h", n, rv, hit, rd, o.lat, o.fault, o.pte);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
